// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and defaults for the GPU frame reader
package gpu_pkg;

    localparam int          DEF_IMG_W     = 100;
    localparam int          DEF_IMG_H     = 100;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous prefetch FIFO holding {last, pixel} entries
// Head entry is read straight from registered storage so consumers never see the RAM data path.
module pixel_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gpu_frame_reader.sv
// rtl/gpu_frame_reader.sv - walks one image frame over the GPU read port and streams pixels
// One read in flight at a time; the prefetch FIFO absorbs consumer backpressure.
module gpu_frame_reader
    import gpu_pkg::*;
#(
    parameter int          IMG_W      = DEF_IMG_W,
    parameter int          IMG_H      = DEF_IMG_H,
    parameter logic [15:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          RD_LATENCY = 1,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        src_sel,
    output logic [15:0] gpu_address,
    input  logic [31:0] gpu_data,
    input  logic [31:0] gpu_data_rom,
    output pixel_t      pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        frame_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int WCW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NPIX - 1);
    localparam logic [WCW-1:0] WAIT_END = WCW'(RD_LATENCY - 2);

    state_t         state_q, state_d;
    logic [15:0]    addr_q, addr_d;
    logic [CW-1:0]  fetch_q, fetch_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           src_q, src_d;
    logic           done_q, done_d;

    logic           fifo_push, fifo_pop, fifo_flush;
    logic           fifo_full, fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic [8:0]     fifo_wdata, fifo_rdata;
    pixel_t         word_px;
    logic           unused_hi;

    assign unused_hi  = ^{gpu_data[31:8], gpu_data_rom[31:8]};
    assign word_px    = src_q ? gpu_data_rom[7:0] : gpu_data[7:0];
    assign fifo_wdata = {fetch_q == LAST_IDX, word_px};
    assign fifo_pop   = pix_ready && !fifo_empty;

    pixel_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_d    = fetch_q;
        wait_d     = wait_q;
        src_d      = src_q;
        done_d     = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (abort) begin
            state_d    = ST_IDLE;
            fetch_d    = '0;
            wait_d     = '0;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_d   = src_sel;
                        addr_d  = BASE_ADDR;
                        fetch_d = '0;
                        wait_d  = '0;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fifo_count != FCW'(FIFO_DEPTH))
                        state_d = (RD_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_END) begin
                        wait_d  = '0;
                        state_d = ST_CAPTURE;
                    end else begin
                        wait_d = wait_q + WCW'(1);
                    end
                end
                ST_CAPTURE: begin
                    fifo_push = !fifo_full;
                    fetch_d   = fetch_q + CW'(1);
                    // Address stays on the final word so IDLE shows the last one read.
                    if (fetch_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = addr_q + 16'd1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_pop && fifo_rdata[8]) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            fetch_q <= '0;
            wait_q  <= '0;
            src_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fetch_q <= fetch_d;
            wait_q  <= wait_d;
            src_q   <= src_d;
            done_q  <= done_d;
        end
    end

    assign gpu_address = addr_q;
    assign pix_valid   = !fifo_empty;
    assign pix_data    = fifo_empty ? 8'h00 : fifo_rdata[7:0];
    assign pix_last    = !fifo_empty && fifo_rdata[8];
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;

endmodule
